asynrecounter10: RTL and testbench



---
 rtl/asynrecounter10_pkg.sv | 11 +
 rtl/asynrecounter10.sv | 40 ++++
 tb/tb_asynrecounter10.sv | 106 ++++++++++
 3 files changed

// File: rtl/asynrecounter10_pkg.sv
// Shared constants and count type for the decade counter and its consumers.
// Defaults give a BCD digit: modulus 10 in a 4-bit register.
`timescale 1ns/1ps
package asynrecounter10_pkg;

  localparam int DEFAULT_MODULUS = 10;
  localparam int DEFAULT_WIDTH   = 4;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage

// File: rtl/asynrecounter10.sv
// Mod-MODULUS up-counter, one step per clk rise, async active-high clear.
// Latency: q is the state register itself; no enable, load or backpressure.
`timescale 1ns/1ps
module asynrecounter10
  import asynrecounter10_pkg::*;
#(
  parameter int MODULUS = DEFAULT_MODULUS,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Anything at or above LAST (including unreachable upset values) returns to 0.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q >= LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

  a_q_in_range : assert property (@(posedge clk) disable iff (reset) cnt_q < WIDTH'(MODULUS));

endmodule

// File: tb/tb_asynrecounter10.sv
// Randomized bench for asynrecounter10 against an arithmetic mod-10 model.
`timescale 1ns/100ps
module tb_asynrecounter10;

  localparam int MOD = 10;
  localparam int W   = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] q;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q  = 0;

  asynrecounter10 #(.MODULUS(MOD), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #90000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int got, input int expv);
    n_chk++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
  endtask

  // One rising edge: update the model, check just after the edge and again
  // just after the following falling edge. Returns in the clk-low phase.
  task automatic tick(input string tag);
    @(posedge clk);
    if (reset) exp_q = 0;
    else       exp_q = (exp_q + 1) % MOD;
    #1;
    chk(tag, int'(q), exp_q);
    chk("range", int'(q < MOD), 1);
    @(negedge clk);
    #1;
    chk({tag, "_hold"}, int'(q), exp_q);
  endtask

  task automatic pulse_reset(input int hold_edges);
    reset = 1'b1;
    exp_q = 0;
    #1;
    chk("async_clear", int'(q), 0);
    for (int i = 0; i < hold_edges; i++) tick("rst_held");
    #1.5;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    #1;
    chk("por", int'(q), 0);

    // Release coincident with the first rising edge: the flop must see
    // reset still high on that edge, so the release lands in the NBA region.
    @(posedge clk);
    reset <= 1'b0;
    #1;
    chk("release_edge", int'(q), 0);
    @(negedge clk);
    #1;
    chk("t10", int'(q), 0);
    #3.5;
    chk("pre_edge15", int'(q), 0);

    for (int i = 0; i < 10; i++) tick("seq");
    chk("wrap_zero", int'(q), 0);
    tick("dec2");
    tick("dec2");
    chk("at_two", int'(q), 2);

    pulse_reset(0);
    tick("after_async");
    chk("after_async_1", int'(q), 1);
    tick("after_async");

    pulse_reset(3);
    tick("after_held");
    chk("after_held_1", int'(q), 1);

    for (int run = 0; run < 120; run++) begin
      int len;
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) tick("rnd");
      if ($urandom_range(0, 3) != 0) pulse_reset($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
